// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_pkg
// Purpose : Shared constants for the programmable serial pattern detector
//           and its helper counters.
// Contents: match-mode encodings, default parameter values, reset pattern.
// Revision: 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  // Values of the mode_overlap input
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Default geometry; PAT_LEN is legal in 2..MAX_PAT_LEN
  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int MAX_PAT_LEN = 16;

  // Pattern held after reset. All zeros makes a 4-bit instance behave as the
  // legacy four-zero detector when overlap mode is selected.
  localparam logic [MAX_PAT_LEN-1:0] RST_PATTERN = '0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that saturates at 2^W-1 instead of wrapping.
//           Synchronous clear takes priority over increment.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high reset (count -> 0)
//           clr   - synchronous clear
//           inc   - increment request
//           q     - current count
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != C_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign q = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module  : seq_detect_prog
// Purpose : Programmable Moore serial pattern detector. The last PAT_LEN
//           qualified bits are compared with a loadable pattern; matches may
//           overlap or not, and a saturating counter tallies them.
// Ports   : clock        - rising-edge clock
//           reset        - asynchronous active-high reset
//           seq_valid    - qualifies seq_in
//           seq_in       - serial data bit
//           pattern      - pattern to load, MSB is the oldest bit expected
//           pattern_load - synchronous pattern load strobe
//           mode_overlap - 1 = overlapping matches, 0 = non-overlapping
//           count_clr    - synchronous clear of match_count
//           seq_out      - registered match flag (level, held while idle)
//           match_count  - saturating number of matches
// Revision: 1.0 - initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,  // 2..16
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_valid,
  input  logic               seq_in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               pattern_load,
  input  logic               mode_overlap,
  input  logic               count_clr,
  output logic               seq_out,
  output logic [CNT_W-1:0]   match_count
);

  // fill counts 0..PAT_LEN inclusive
  localparam int                 FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]      FILL_FULL = FW'(PAT_LEN);
  localparam logic [PAT_LEN-1:0] PAT_RST   = RST_PATTERN[PAT_LEN-1:0];

  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               seq_out_q;

  logic               qual;
  logic [FW-1:0]      fill_inc;
  logic               match;

  // A load strobe wins over a same-cycle data bit, which is dropped.
  assign qual = seq_valid && !pattern_load;

  always_comb begin
    hist_d   = {hist_q[PAT_LEN-2:0], seq_in};
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // Only a full window may match; no partial matches after a restart.
    match    = qual && (fill_inc == FILL_FULL) && (hist_d == pat_q);
    // Non-overlap mode restarts the window so PAT_LEN fresh bits are needed.
    fill_d   = (match && (mode_overlap == MODE_NONOVL)) ? '0 : fill_inc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q     <= PAT_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      seq_out_q <= 1'b0;
    end else if (pattern_load) begin
      // History is kept, but fill restarts so old bits can never match.
      pat_q     <= pattern;
      fill_q    <= '0;
      seq_out_q <= 1'b0;
    end else if (qual) begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      seq_out_q <= match;
    end
  end

  assign seq_out = seq_out_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .inc   (match),
    .q     (match_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_detect_prog
// Purpose : Directed self-checking bench for seq_detect_prog. A second
//           instance with a 2-bit counter shares all inputs to exercise
//           counter saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       seq_valid = 1'b0;
  logic       seq_in = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       pattern_load = 1'b0;
  logic       mode_overlap = 1'b1;
  logic       count_clr = 1'b0;
  logic       seq_out, seq_out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  seq_detect_prog #(.PAT_LEN(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .seq_valid    (seq_valid),
    .seq_in       (seq_in),
    .pattern      (pattern),
    .pattern_load (pattern_load),
    .mode_overlap (mode_overlap),
    .count_clr    (count_clr),
    .seq_out      (seq_out),
    .match_count  (match_count)
  );

  seq_detect_prog #(.PAT_LEN(4), .CNT_W(2)) dut2 (
    .clock        (clock),
    .reset        (reset),
    .seq_valid    (seq_valid),
    .seq_in       (seq_in),
    .pattern      (pattern),
    .pattern_load (pattern_load),
    .mode_overlap (mode_overlap),
    .count_clr    (count_clr),
    .seq_out      (seq_out2),
    .match_count  (match_count2)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic b);
    seq_valid = 1'b1;
    seq_in    = b;
    tick();
    seq_valid = 1'b0;
  endtask

  task automatic clear_count();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
  endtask

  task automatic load_pat(input logic [3:0] p);
    pattern      = p;
    pattern_load = 1'b1;
    tick();
    pattern_load = 1'b0;
  endtask

  // Send a stream (MSB-first in bits[n-1:0]) and check seq_out after each bit
  task automatic stream(input string tag, input int n, input logic [7:0] bits,
                        input logic [7:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      chk_val($sformatf("%s_bit%0d", tag, n - i), 32'(seq_out), 32'(exp[i]));
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    chk_val("rst_seq_out", 32'(seq_out), 0);
    chk_val("rst_count", 32'(match_count), 0);
    reset = 1'b0;
    tick();

    // ---------------- legacy four-zero behaviour ----------------
    mode_overlap = 1'b1;
    stream("zeros", 6, 8'b000001, 8'b000110);
    chk_val("zeros_count", 32'(match_count), 2);
    clear_count();
    chk_val("clr_count", 32'(match_count), 0);

    // ---------------- pattern 1011, overlap ----------------
    load_pat(4'b1011);
    chk_val("load_seq_out", 32'(seq_out), 0);
    stream("ovl", 7, 8'b1011011, 8'b0001001);
    chk_val("ovl_count", 32'(match_count), 2);

    // ---------------- pattern 1011, non-overlap ----------------
    load_pat(4'b1011);
    clear_count();
    mode_overlap = 1'b0;
    stream("novl", 7, 8'b1011011, 8'b0001000);
    chk_val("novl_count", 32'(match_count), 1);

    // ---------------- valid gaps, held Moore level ----------------
    load_pat(4'b1011);
    clear_count();
    mode_overlap = 1'b1;
    send(1'b1); repeat (3) tick();
    send(1'b0); repeat (3) tick();
    send(1'b1); repeat (3) tick();
    chk_val("gap_pre", 32'(seq_out), 0);
    send(1'b1);
    chk_val("gap_match", 32'(seq_out), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val($sformatf("gap_hold%0d", i), 32'(seq_out), 1);
    end
    chk_val("gap_count", 32'(match_count), 1);

    // ---------------- load collides with completing bit ----------------
    load_pat(4'b1011);
    clear_count();
    send(1'b1); send(1'b0); send(1'b1);
    pattern      = 4'b1011;
    pattern_load = 1'b1;
    seq_valid    = 1'b1;
    seq_in       = 1'b1;
    tick();
    pattern_load = 1'b0;
    seq_valid    = 1'b0;
    chk_val("coll_seq_out", 32'(seq_out), 0);
    chk_val("coll_count", 32'(match_count), 0);
    stream("coll", 4, 8'b1011, 8'b0001);
    chk_val("coll_count2", 32'(match_count), 1);

    // ---------------- saturation and clear priority ----------------
    load_pat(4'b1111);
    clear_count();
    for (int i = 0; i < 8; i++) send(1'b1);
    chk_val("sat_seq_out", 32'(seq_out), 1);
    chk_val("sat_count8", 32'(match_count), 5);
    chk_val("sat_count2", 32'(match_count2), 3);
    count_clr = 1'b1;
    send(1'b1);
    count_clr = 1'b0;
    chk_val("clrm_seq_out", 32'(seq_out), 1);
    chk_val("clrm_count8", 32'(match_count), 0);
    chk_val("clrm_count2", 32'(match_count2), 0);
    send(1'b1);
    chk_val("after_clr_count", 32'(match_count), 1);

    // ---------------- async reset mid-stream ----------------
    send(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_val("arst_seq_out", 32'(seq_out), 0);
    chk_val("arst_count", 32'(match_count), 0);
    chk_val("arst_count2", 32'(match_count2), 0);
    #1;
    reset = 1'b0;
    tick();
    // Pattern returns to all zeros; a 1-run must not match, zeros must.
    stream("post_rst", 6, 8'b110000, 8'b000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Programmable, parametrised Moore serial pattern detector; next generation of the team's fixed 4-bit zero-run detectors.
- Compares the last PAT_LEN qualified serial bits against a loadable pattern register.
- Supports overlapping and non-overlapping match modes and keeps a saturating match counter.
- Sits between the serial bit source (switch/debounce front end) and the display/LED output logic of the string-recognition datapath.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of match_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seq_valid  in  1  qualifies seq_in; the state advances only when this is 1.
- seq_in  in  1  serial data bit.
- pattern  in  PAT_LEN  pattern to load; pattern[PAT_LEN-1] is the first (oldest) bit expected.
- pattern_load  in  1  synchronous load strobe for pattern.
- mode_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- count_clr  in  1  synchronous clear of match_count.
- seq_out  out  1  Moore match flag, registered.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (async): pat_reg=0, hist=0, fill=0, seq_out=0, match_count=0.
  - With the reset pattern (all zeros) and mode_overlap=1, the block behaves exactly as the legacy four-zero detector when PAT_LEN=4.
- State: hist (PAT_LEN-bit shift register), fill (0..PAT_LEN, number of valid bits held), pat_reg.
- Qualified bit (seq_valid=1, pattern_load=0):
  - hist_n = {hist[PAT_LEN-2:0], seq_in}.
  - fill_n = min(fill+1, PAT_LEN).
  - match = (fill_n==PAT_LEN) && (hist_n==pat_reg).
  - On the same edge: hist<=hist_n; seq_out<=match.
  - fill <= (match && !mode_overlap) ? 0 : fill_n.
- Latency: seq_out rises on the clock edge that samples the last pattern bit, i.e. it is visible the cycle after that bit is presented.
- seq_valid=0: no state change; seq_out holds its value (Moore level, not a pulse).
- Overlap mode: a continued matching stream keeps seq_out=1 on every qualified bit that completes a match.
- Non-overlap mode: after a match, PAT_LEN fresh bits are required before the next match; seq_out drops on the next qualified bit.
- pattern_load=1: pat_reg<=pattern; fill<=0; seq_out<=0; hist unchanged.
  - pattern_load has priority over a simultaneous qualified bit; that bit is discarded.
- mode_overlap is sampled only on qualified-bit edges; a change takes effect at the next qualified bit.
- match_count:
  - Increments by 1 on every edge where match=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - count_clr=1 forces 0 and has priority over a same-cycle match (that match is not counted).
  - count_clr does not affect seq_out or the detector state.
- Reset asserted mid-stream: all state clears immediately; the partial history is lost.
- A pattern shorter than the bits received so far is never matched until fill reaches PAT_LEN; no partial matches are reported.

Decomposition:
- Shared package seq_detect_pkg:
  - MODE_NONOVL=1'b0 and MODE_OVL=1'b1 constants.
  - Default PAT_LEN/CNT_W localparams.
  - Reset pattern constant (all zeros).
- One sub-module, sat_counter (parameter W; inputs clr, inc; output q, saturating). It is reused for match_count and is intended for later error/statistics counters.

Test Plan:
- Reset, PAT_LEN=4, mode_overlap=1, stream 0,0,0,0,0,1 (all valid) -> seq_out 0,0,0,1,1,0 after each bit; match_count=2.
- Load pattern 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> seq_out high after bit 4 and after bit 7; match_count=2.
- Same pattern, overlap=0, stream 1,0,1,1,0,1,1 -> single match after bit 4 only; match_count=1.
- Stream 1,0,1 with seq_valid gaps of 3 idle cycles between bits, then 1 -> match after the 4th valid bit only; seq_out held high through subsequent idle cycles.
- pattern_load asserted together with a valid bit completing a match -> no match, seq_out=0, fill=0, match_count unchanged; then 4 new matching bits -> match.
- CNT_W=2, 5 consecutive overlap matches -> match_count saturates at 3; count_clr together with a match -> match_count=0. Async reset mid-stream -> all outputs 0 immediately.
